// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, drives the ibus request and hands
// {pc, raw_instr} to IF/ID. A raw_instr of zero marks a bubble.
package fetch_pkg;
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] raw_instr;
  } fetch_data_t;
endpackage

module fetch
  import fetch_pkg::*;
#(
  parameter logic [63:0] PC_RESET = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        stallM,
  input  logic        jump,
  input  logic [63:0] jump_target,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output fetch_data_t dataF
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,  // request for pc outstanding
    S_HOLD  = 2'd1,  // instruction captured, waiting for IF/ID to accept
    S_FLUSH = 2'd2   // stale request outstanding, its data is dropped
  } state_t;

  state_t      r_state;
  logic [63:0] r_pc;
  logic [31:0] r_hold_instr;
  logic [63:0] r_pend_target;

  state_t      w_state_nxt;
  logic [63:0] w_pc_nxt;
  logic [31:0] w_hold_nxt;
  logic [63:0] w_pend_nxt;
  logic [31:0] w_raw_instr;
  logic        w_advance;

  assign w_advance = ~stall & ~stallM;

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_FETCH;
      r_pc          <= PC_RESET;
      r_hold_instr  <= '0;
      r_pend_target <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_hold_instr  <= w_hold_nxt;
      r_pend_target <= w_pend_nxt;
    end
  end

  // Next-state logic and the instruction presented to IF/ID
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_hold_nxt  = r_hold_instr;
    w_pend_nxt  = r_pend_target;
    w_raw_instr = '0;
    unique case (r_state)
      S_FETCH: begin
        if (iresp_data_ok) begin
          if (jump) begin
            w_pc_nxt = jump_target;
          end else if (w_advance) begin
            w_pc_nxt    = r_pc + 64'd4;
            w_raw_instr = iresp_data;
          end else begin
            w_hold_nxt  = iresp_data;
            w_state_nxt = S_HOLD;
            w_raw_instr = iresp_data;
          end
        end else if (jump) begin
          w_pend_nxt  = jump_target;
          w_state_nxt = S_FLUSH;
        end
      end
      S_HOLD: begin
        w_raw_instr = r_hold_instr;
        if (jump) begin
          w_pc_nxt    = jump_target;
          w_state_nxt = S_FETCH;
        end else if (w_advance) begin
          w_pc_nxt    = r_pc + 64'd4;
          w_state_nxt = S_FETCH;
        end
      end
      S_FLUSH: begin
        if (jump) w_pend_nxt = jump_target;
        if (iresp_data_ok) begin
          w_pc_nxt    = jump ? jump_target : r_pend_target;
          w_state_nxt = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
    if (reset) w_raw_instr = '0;
  end

  assign ireq_valid      = ((r_state == S_FETCH) || (r_state == S_FLUSH)) & ~reset;
  assign ireq_addr       = r_pc;
  assign dataF.pc        = r_pc;
  assign dataF.raw_instr = w_raw_instr;

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: the bench plays the ibus and the pipeline
// control inputs and checks the request and IF/ID outputs every cycle.
module tb_fetch;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall, stallM, jump, iresp_data_ok;
  logic [63:0] jump_target;
  logic [31:0] iresp_data;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  fetch_data_t dataF;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  fetch #(.PC_RESET(64'h8000_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .stallM(stallM),
    .jump(jump), .jump_target(jump_target),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .dataF(dataF)
  );

  // Apply one cycle's inputs mid-period, then let combinational outputs settle.
  task automatic drive(input logic r, input logic st, input logic sm,
                       input logic j, input logic [63:0] jt,
                       input logic ok, input logic [31:0] d);
    @(negedge clk);
    reset = r; stall = st; stallM = sm; jump = j; jump_target = jt;
    iresp_data_ok = ok; iresp_data = d;
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check request valid/address, IF/ID pc (== request address) and raw_instr.
  task automatic expect_out(input string tag, input logic v,
                            input logic [63:0] addr, input logic [31:0] raw);
    chk({tag, ".valid"}, {63'd0, ireq_valid}, {63'd0, v});
    chk({tag, ".addr"}, ireq_addr, addr);
    chk({tag, ".pc"}, dataF.pc, addr);
    chk({tag, ".raw"}, {32'd0, dataF.raw_instr}, {32'd0, raw});
  endtask

  initial begin
    // Reset: second reset cycle shows PC_RESET, no request, bubble
    drive(1, 0, 0, 0, 64'h0, 0, 32'h0);
    drive(1, 0, 0, 0, 64'h0, 1, 32'hFFFF_FFFF);
    expect_out("reset", 0, 64'h8000_0000, 32'h0);

    // Zero-wait bus: one instruction per cycle
    drive(0, 0, 0, 0, 64'h0, 1, 32'h8000_0000);
    expect_out("zw0", 1, 64'h8000_0000, 32'h8000_0000);
    drive(0, 0, 0, 0, 64'h0, 1, 32'h8000_0004);
    expect_out("zw1", 1, 64'h8000_0004, 32'h8000_0004);
    drive(0, 0, 0, 0, 64'h0, 1, 32'h8000_0008);
    expect_out("zw2", 1, 64'h8000_0008, 32'h8000_0008);

    // 3-wait response: bubbles with a stable address, then the word
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 64'h0, 0, 32'h1234_5678);
      expect_out("wait", 1, 64'h8000_000C, 32'h0);
    end
    drive(0, 0, 0, 0, 64'h0, 1, 32'hDEAD_BEEF);
    expect_out("wait_ok", 1, 64'h8000_000C, 32'hDEAD_BEEF);

    // Stall in the data_ok cycle: HOLD repeats the word, no request
    drive(0, 1, 0, 0, 64'h0, 1, 32'h1111_2222);
    expect_out("stall_ok", 1, 64'h8000_0010, 32'h1111_2222);
    drive(0, 0, 1, 0, 64'h0, 0, 32'h0);
    expect_out("hold0", 0, 64'h8000_0010, 32'h1111_2222);
    drive(0, 0, 0, 0, 64'h0, 0, 32'h0);
    expect_out("hold1", 0, 64'h8000_0010, 32'h1111_2222);

    // Jump beats stall in a zero-wait data_ok cycle; output squashed
    drive(0, 1, 0, 1, 64'h8000_1000, 1, 32'h3333_4444);
    expect_out("jmp_ok", 1, 64'h8000_0014, 32'h0);

    // Jump mid-request, second jump while flushing; stale data dropped
    drive(0, 0, 0, 0, 64'h0, 0, 32'h0);
    expect_out("jt1000", 1, 64'h8000_1000, 32'h0);
    drive(0, 0, 0, 1, 64'h8000_2000, 0, 32'h0);
    expect_out("jmid", 1, 64'h8000_1000, 32'h0);
    drive(0, 0, 0, 1, 64'h8000_3000, 0, 32'h0);
    expect_out("flush0", 1, 64'h8000_1000, 32'h0);
    drive(0, 0, 0, 0, 64'h0, 1, 32'h5555_6666);
    expect_out("flush_ok", 1, 64'h8000_1000, 32'h0);
    drive(0, 0, 0, 0, 64'h0, 1, 32'h7777_8888);
    expect_out("jt3000", 1, 64'h8000_3000, 32'h7777_8888);

    // Reset while in HOLD
    drive(0, 1, 0, 0, 64'h0, 1, 32'h9999_AAAA);
    expect_out("to_hold", 1, 64'h8000_3004, 32'h9999_AAAA);
    drive(1, 1, 0, 0, 64'h0, 0, 32'h0);
    expect_out("rst_hold", 0, 64'h8000_3004, 32'h0);
    drive(0, 0, 0, 0, 64'h0, 0, 32'h0);
    expect_out("post_rst1", 1, 64'h8000_0000, 32'h0);

    // Flush ending with data_ok and a jump in the same cycle: that jump wins
    drive(0, 0, 0, 1, 64'h8000_4000, 0, 32'h0);
    expect_out("jmid2", 1, 64'h8000_0000, 32'h0);
    drive(0, 0, 0, 1, 64'h8000_5000, 1, 32'hBBBB_CCCC);
    expect_out("flush_jok", 1, 64'h8000_0000, 32'h0);
    drive(0, 0, 0, 0, 64'h0, 0, 32'h0);
    expect_out("jt5000", 1, 64'h8000_5000, 32'h0);

    // Reset while in FLUSH
    drive(0, 0, 0, 1, 64'h8000_6000, 0, 32'h0);
    expect_out("jmid3", 1, 64'h8000_5000, 32'h0);
    drive(1, 0, 0, 0, 64'h0, 1, 32'hEEEE_FFFF);
    expect_out("rst_flush", 0, 64'h8000_5000, 32'h0);
    drive(0, 0, 0, 0, 64'h0, 0, 32'h0);
    expect_out("post_rst2", 1, 64'h8000_0000, 32'h0);

    // PC wraps modulo 2^64
    drive(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 32'h0BAD_0BAD);
    expect_out("jmp_top", 1, 64'h8000_0000, 32'h0);
    drive(0, 0, 0, 0, 64'h0, 1, 32'hABCD_0123);
    expect_out("top", 1, 64'hFFFF_FFFF_FFFF_FFFC, 32'hABCD_0123);
    drive(0, 0, 0, 0, 64'h0, 0, 32'h0);
    expect_out("wrap", 1, 64'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch.md
# fetch

Instruction-fetch stage of the pipeline: owns the architectural PC, issues instruction requests on the ibus, and presents `dataF` (pc, raw_instr) to the IF/ID register. It absorbs variable ibus latency, downstream stalls and jump redirects; cycles with nothing valid to hand over are emitted as bubbles (`raw_instr == 0`).

## Interface
- `PC_RESET`, 64'h8000_0000, PC loaded on reset.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  decode-side hazard stall; IF/ID does not accept this cycle.
- `stallM`  in  1  memory-stage stall; IF/ID does not accept this cycle.
- `jump`  in  1  redirect request; current fetch output is squashed.
- `jump_target`  in  64  redirect PC, valid when `jump`.
- `ireq_valid`  out  1  ibus request valid.
- `ireq_addr`  out  64  ibus request address.
- `iresp_data_ok`  in  1  ibus response; `iresp_data` valid this cycle; ends the request.
- `iresp_data`  in  32  fetched instruction word.
- `dataF`  out  fetch_data_t  `{pc[63:0], raw_instr[31:0]}` to IF/ID.

## Operation
- Define `advance = ~stall & ~stallM`. Priority per cycle: `reset` > `jump` > stall > normal.
- Bus rule: once `ireq_valid` rises, `ireq_valid` and `ireq_addr` stay stable until the cycle `iresp_data_ok` is seen; requests are never withdrawn. `ireq_valid = (state==FETCH || state==FLUSH) & ~reset`; `ireq_addr = pc`.
- States:
  - FETCH: request for `pc` outstanding.
    - `data_ok & jump`: pc <= jump_target; stay FETCH; output squashed.
    - `data_ok & advance`: pc <= pc+4; stay FETCH.
    - `data_ok & ~advance`: hold_instr <= iresp_data; -> HOLD.
    - `~data_ok & jump`: pend_target <= jump_target; -> FLUSH.
    - else stay.
  - HOLD: instruction captured, no request.
    - `jump`: pc <= jump_target; -> FETCH.
    - `advance`: pc <= pc+4; -> FETCH.
    - else stay.
  - FLUSH: stale request outstanding, its data is discarded.
    - `jump` (any cycle): pend_target <= jump_target (latest wins).
    - `data_ok`: pc <= (jump ? jump_target : pend_target); -> FETCH.
- `dataF.pc = pc` always.
- `dataF.raw_instr`: FETCH with `data_ok` → `iresp_data` (combinational bypass); HOLD → `hold_instr`; otherwise 32'h0.
- PC arithmetic: 64-bit, pc+4 wraps modulo 2^64; no alignment check; `jump_target` used verbatim.
- Bubble encoding is `raw_instr == 0`; a fetched word of 0 is indistinguishable and is not special-cased.

## Timing
- Reset (cycle with `reset`=1): pc <= PC_RESET, state <= FETCH, hold_instr <= 0, pend_target <= 0. Outputs during reset: `ireq_valid`=0, `ireq_addr`=pc, `dataF.raw_instr`=0.
- First request: the cycle after `reset` deasserts, `ireq_valid`=1, `ireq_addr`=PC_RESET.
- Zero-wait ibus (`data_ok` in the request cycle): one instruction per cycle, zero added latency, new address next cycle.
- N-wait ibus: `dataF.raw_instr`=0 for N cycles, then the instruction in the `data_ok` cycle.
- Stall in the `data_ok` cycle: instruction appears from HOLD next cycle and is repeated each cycle until `advance` or `jump`; no new request while in HOLD.
- Jump with no outstanding request (HOLD, or FETCH with `data_ok`): target requested the next cycle.
- Jump mid-request: penalty = remaining wait + 1 cycle; no stale instruction is ever output.
- `reset` in any state aborts immediately; an ibus response arriving during or after reset for a pre-reset request is the bus's responsibility and is not filtered.

## Test plan
- Reset, zero-wait bus returning pc[31:0] as data -> `ireq_addr` 8000_0000, 8000_0004, 8000_0008 on consecutive cycles; `raw_instr` matches each.
- `data_ok` 3 cycles after request -> `raw_instr`=0 for 3 cycles, then the word; `ireq_addr` stable across the wait.
- Stall asserted for 2 cycles in the `data_ok` cycle for 8000_0004 -> `ireq_valid`=0 for 2 cycles; `dataF` holds {8000_0004, word}; then `ireq_addr`=8000_0008.
- Jump to 8000_1000 in a zero-wait `data_ok` cycle with stall also high -> jump wins; next `ireq_addr`=8000_1000.
- Jump to 8000_2000 one cycle into a 3-wait request, second jump to 8000_3000 a cycle later -> `raw_instr`=0 throughout, stale data dropped, next `ireq_addr`=8000_3000.
- Reset asserted while in HOLD and again while in FLUSH -> next cycle `ireq_valid`=1, `ireq_addr`=8000_0000, `raw_instr`=0.
